// File: rtl/mic_frame_scheduler.sv
// mic_frame_scheduler: ping/pong capture of mic samples into stream frames.
// Define MIC_FRAME_SEQ_NUM_EN to prepend a {16'hA55A, seq} header per frame.
module mic_frame_scheduler #(
  parameter int SAMPLES_PER_FRAME = 256,
  parameter int OVF_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [31:0]      mic_data,
  input  logic             mic_data_valid,
  output logic [31:0]      m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [OVF_W-1:0] overflow_count,
  output logic             busy
);

  localparam int AW = $clog2(SAMPLES_PER_FRAME);
  localparam logic [AW-1:0] LAST_IDX = AW'(SAMPLES_PER_FRAME - 1);

`ifdef MIC_FRAME_SEQ_NUM_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HDR    = 2'd1,
    STREAM = 2'd2,
    LAST   = 2'd3
  } st_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd2,
    LAST   = 2'd3
  } st_t;
`endif

  logic [31:0]   mem [2*SAMPLES_PER_FRAME];

  st_t           st;
  logic [1:0]    committed;
  logic          fill_bank;
  logic [AW-1:0] wr_idx;
  logic          rd_bank;
  logic [AW-1:0] rd_idx;
`ifdef MIC_FRAME_SEQ_NUM_EN
  logic [15:0]   seq;
`endif

  logic [1:0]    fr;
  logic [1:0]    cm;
  logic          samp;
  logic          stall;
  logic          alt;
  logic          wbank;
  logic [AW-1:0] widx;
  logic          wen;
  logic          drop;
  logic          commit;
  logic [AW-1:0] nidx;
  logic [31:0]   rword;

  // bank released by the final handshake of a frame
  always_comb begin
    fr = 2'b00;
    if (st == LAST && m_tready) begin
      fr = rd_bank ? 2'b10 : 2'b01;
    end
  end

  // write target: fill bank, or a bank freed this very cycle when stalled
  always_comb begin
    samp   = enable & mic_data_valid;
    stall  = committed[fill_bank];
    alt    = ~fill_bank;
    wbank  = fill_bank;
    widx   = wr_idx;
    wen    = samp;
    drop   = 1'b0;
    if (stall) begin
      wbank = alt;
      widx  = '0;
      wen   = samp & fr[alt];
      drop  = samp & ~fr[alt];
    end
    commit = wen && widx == LAST_IDX;
    cm     = 2'b00;
    if (commit) begin
      cm = wbank ? 2'b10 : 2'b01;
    end
  end

  // sample RAM, no reset needed
  always_ff @(posedge clk) begin
    if (wen) begin
      mem[{wbank, widx}] <= mic_data;
    end
  end

  // bank status, fill pointer and drop counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      committed      <= 2'b00;
      fill_bank      <= 1'b0;
      wr_idx         <= '0;
      overflow_count <= '0;
    end else begin
      committed <= (committed & ~fr) | cm;
      if (!enable) begin
        wr_idx <= '0;
      end else if (wen) begin
        wr_idx <= widx + 1'b1;
      end
      if (commit) begin
        if (!committed[alt] || fr[alt]) begin
          fill_bank <= alt;
        end
      end else if (stall && fr[alt]) begin
        fill_bank <= alt;
      end
      if (drop && overflow_count != '1) begin
        overflow_count <= overflow_count + 1'b1;
      end
    end
  end

  assign nidx  = (st == STREAM) ? rd_idx + 1'b1 : '0;
  assign rword = mem[{rd_bank, nidx}];

  // read FSM with registered stream outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st       <= IDLE;
      rd_bank  <= 1'b0;
      rd_idx   <= '0;
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
`ifdef MIC_FRAME_SEQ_NUM_EN
      seq      <= '0;
`endif
    end else begin
      case (st)
        IDLE: begin
          if (committed[rd_bank]) begin
            m_tvalid <= 1'b1;
            rd_idx   <= '0;
`ifdef MIC_FRAME_SEQ_NUM_EN
            m_tdata  <= {16'hA55A, seq};
            st       <= HDR;
`else
            m_tdata  <= rword;
            st       <= STREAM;
`endif
          end
        end
`ifdef MIC_FRAME_SEQ_NUM_EN
        HDR: begin
          if (m_tready) begin
            m_tdata <= rword;
            seq     <= seq + 16'd1;
            st      <= STREAM;
          end
        end
`endif
        STREAM: begin
          if (m_tready) begin
            m_tdata <= rword;
            rd_idx  <= nidx;
            if (nidx == LAST_IDX) begin
              m_tlast <= 1'b1;
              st      <= LAST;
            end
          end
        end
        LAST: begin
          if (m_tready) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            rd_bank  <= ~rd_bank;
            st       <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign busy = (|committed) || (st != IDLE);

endmodule

// File: tb/tb_mic_frame_scheduler.sv
// tb_mic_frame_scheduler: directed and random frames against a queue model.
// Frame words and drop counts come from an abstract held-frame model.
module tb_mic_frame_scheduler;

  localparam int SPF = 16;
`ifdef MIC_FRAME_SEQ_NUM_EN
  localparam int WPF = SPF + 1;
`else
  localparam int WPF = SPF;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] mic_data;
  logic        mic_data_valid;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [3:0]  overflow_count;
  logic        busy;

  mic_frame_scheduler #(
    .SAMPLES_PER_FRAME(SPF),
    .OVF_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .mic_data(mic_data),
    .mic_data_valid(mic_data_valid),
    .m_tdata(m_tdata),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tlast(m_tlast),
    .overflow_count(overflow_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [32:0] expq[$];
  logic [31:0] part[$];
  int          held = 0;
  int          xfers = 0;
  logic [3:0]  ovf = 4'd0;
  logic [15:0] seq = 16'd0;
  logic        prev_hold = 1'b0;
  logic [31:0] hd;
  logic        hl;

  task automatic step();
    logic [32:0] w;
    @(negedge clk);
    n_chk++;
    assert (busy === (held != 0)) else begin
      n_fail++;
      $error("FAIL busy obs=%0b exp=%0b", busy, held != 0);
    end
    n_chk++;
    assert (overflow_count === ovf) else begin
      n_fail++;
      $error("FAIL ovf obs=%0d exp=%0d", overflow_count, ovf);
    end
    if (!rst_n) begin
      expq.delete();
      part.delete();
      held = 0;
      ovf = 4'd0;
      seq = 16'd0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        n_chk++;
        assert (m_tvalid === 1'b1 && m_tdata === hd && m_tlast === hl)
        else begin
          n_fail++;
          $error("FAIL stall_hold obs=%0b/%0h/%0b exp=1/%0h/%0b",
                 m_tvalid, m_tdata, m_tlast, hd, hl);
        end
      end
      if (m_tvalid) begin
        n_chk++;
        assert (expq.size() != 0) else begin
          n_fail++;
          $error("FAIL spurious_valid obs=%0h exp=none", m_tdata);
        end
      end
      if (m_tvalid && m_tready && expq.size() != 0) begin
        w = expq.pop_front();
        n_chk++;
        assert (m_tdata === w[31:0]) else begin
          n_fail++;
          $error("FAIL tdata obs=%0h exp=%0h", m_tdata, w[31:0]);
        end
        n_chk++;
        assert (m_tlast === w[32]) else begin
          n_fail++;
          $error("FAIL tlast obs=%0b exp=%0b", m_tlast, w[32]);
        end
        xfers++;
        if (w[32]) held--;
      end
      prev_hold = m_tvalid && !m_tready;
      hd = m_tdata;
      hl = m_tlast;
      if (!enable) begin
        part.delete();
      end else if (mic_data_valid) begin
        if (held == 2) begin
          if (ovf != 4'hF) ovf = ovf + 4'd1;
        end else begin
          part.push_back(mic_data);
          if (part.size() == SPF) begin
`ifdef MIC_FRAME_SEQ_NUM_EN
            expq.push_back({1'b0, 16'hA55A, seq});
            seq = seq + 16'd1;
`endif
            for (int i = 0; i < SPF; i++)
              expq.push_back({(i == SPF - 1), part[i]});
            part.delete();
            held++;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    mic_data = d;
    mic_data_valid = 1'b1;
    step();
    mic_data_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    m_tready = 1'b1;
    mic_data_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (expq.size() == 0 && !m_tvalid) break;
      step();
    end
    n_chk++;
    assert (expq.size() == 0) else begin
      n_fail++;
      $error("FAIL %s obs=%0d exp=0 words left", tag, expq.size());
    end
  endtask

  initial begin
    int lat;
    int base;
    rst_n = 1'b0;
    enable = 1'b0;
    mic_data = '0;
    mic_data_valid = 1'b0;
    m_tready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    n_chk++;
    assert (m_tvalid === 1'b0 && m_tlast === 1'b0 && m_tdata === 32'd0)
    else begin
      n_fail++;
      $error("FAIL reset_out obs=%0b/%0b/%0h exp=0/0/0",
             m_tvalid, m_tlast, m_tdata);
    end
    n_chk++;
    assert (busy === 1'b0 && overflow_count === 4'd0) else begin
      n_fail++;
      $error("FAIL reset_stat obs=%0b/%0d exp=0/0", busy, overflow_count);
    end

    // slow frame 0..15, ready high: latency and gapless burst
    enable = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i < SPF; i++) begin
      send(32'(i));
      if (i != SPF - 1) repeat (3) step();
    end
    lat = 0;
    while (!m_tvalid && lat < 5) begin
      step();
      lat++;
    end
    n_chk++;
    assert (lat <= 3) else begin
      n_fail++;
      $error("FAIL latency obs=%0d exp<=3", lat);
    end
    base = xfers;
    repeat (WPF) step();
    n_chk++;
    assert (xfers - base == WPF) else begin
      n_fail++;
      $error("FAIL no_bubble obs=%0d exp=%0d", xfers - base, WPF);
    end
    drain("drain_a");

    // ready toggling every cycle
    m_tready = 1'b0;
    for (int i = 0; i < SPF; i++) begin
      m_tready = ~m_tready;
      send($urandom);
    end
    for (int i = 0; i < 3 * WPF; i++) begin
      m_tready = ~m_tready;
      step();
    end
    drain("drain_b");

    // both banks full: 8 drops
    m_tready = 1'b0;
    for (int i = 0; i < 40; i++) send(32'h100 + 32'(i));
    n_chk++;
    assert (overflow_count === 4'd8 && busy === 1'b1) else begin
      n_fail++;
      $error("FAIL overflow8 obs=%0d/%0b exp=8/1", overflow_count, busy);
    end
    drain("drain_c");

    // saturation of the drop counter
    m_tready = 1'b0;
    for (int i = 0; i < 2 * SPF + 20; i++) send($urandom);
    n_chk++;
    assert (overflow_count === 4'hF) else begin
      n_fail++;
      $error("FAIL ovf_sat obs=%0d exp=15", overflow_count);
    end
    drain("drain_d");

    // enable drop discards a partial frame
    for (int i = 0; i < 5; i++) send(32'hDEAD0000 + 32'(i));
    enable = 1'b0;
    step();
    enable = 1'b1;
    for (int i = 0; i < SPF; i++) send(32'h200 + 32'(i));
    drain("drain_e");

    // reset at word 7 of a streaming frame
    for (int i = 0; i < SPF; i++) send($urandom);
    base = xfers;
    for (int i = 0; i < 60; i++) begin
      if (xfers - base >= 7) break;
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_chk++;
    assert (m_tvalid === 1'b0 && busy === 1'b0 && overflow_count === 4'd0)
    else begin
      n_fail++;
      $error("FAIL mid_reset obs=%0b/%0b/%0d exp=0/0/0",
             m_tvalid, busy, overflow_count);
    end
    for (int i = 0; i < SPF; i++) send(32'h300 + 32'(i));
    drain("drain_f");

    // random traffic
    for (int i = 0; i < 800; i++) begin
      enable = ($urandom_range(0, 60) != 0);
      mic_data_valid = ($urandom_range(0, 2) != 0);
      mic_data = $urandom;
      m_tready = ($urandom_range(0, 3) != 0);
      step();
    end
    mic_data_valid = 1'b0;
    drain("drain_g");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mic_frame_scheduler.md
MIC_FRAME_SCHEDULER -- requirements
Module: mic_frame_scheduler

Interface
REQ-001 The block SHALL have parameter SAMPLES_PER_FRAME, default 256, giving the number of mic samples per output frame (power of two, 16..1024).
REQ-002 The block SHALL have parameter OVF_W, default 16, giving the width of the overflow counter.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 enable  in  1  capture enable from control logic.
REQ-006 mic_data  in  32  CIC-decimated PCM sample from the PDM microphone path.
REQ-007 mic_data_valid  in  1  one-cycle strobe marking mic_data valid; no backpressure.
REQ-008 m_tdata  out  32  frame word to the Ethernet packetiser.
REQ-009 m_tvalid  out  1  m_tdata valid.
REQ-010 m_tready  in  1  downstream accept.
REQ-011 m_tlast  out  1  final word of frame.
REQ-012 overflow_count  out  OVF_W  count of dropped samples, saturating.
REQ-013 busy  out  1  high while any bank holds a committed or streaming frame.

Function
REQ-014 The block SHALL have two sample banks (ping/pong), each SAMPLES_PER_FRAME x 32, with a write side and a read side.
REQ-015 Write side: when enable=1 and mic_data_valid=1, the block SHALL store mic_data at the write index of the fill bank and increment the index.
REQ-016 Frame commit: when the index wraps from SAMPLES_PER_FRAME-1 to 0, the block SHALL mark the fill bank committed and switch fill to the other bank only if that bank is free.
REQ-017 No free bank: the block SHALL drop each valid sample, increment overflow_count (saturate at all-ones), and resume at index 0 of the first bank freed.
REQ-018 Simultaneous events: a bank freed in the same cycle a sample arrives SHALL accept that sample; it is not dropped.
REQ-019 enable falling mid-frame SHALL discard the partial frame (index to 0, bank stays free); committed frames SHALL still stream.
REQ-020 Read FSM states SHALL be IDLE, HDR (present only per REQ-031), STREAM, LAST.
REQ-021 IDLE->HDR/STREAM when a committed bank exists; oldest committed bank is read first.
REQ-022 STREAM->LAST when presenting word SAMPLES_PER_FRAME-1; LAST->IDLE on handshake, freeing the bank that cycle.
REQ-023 A word SHALL transfer only when m_tvalid=1 and m_tready=1; m_tdata, m_tlast SHALL be held stable while m_tvalid=1 and m_tready=0.
REQ-024 m_tvalid SHALL assert no later than 3 clk after the cycle that commits a frame while the read FSM is in IDLE.
REQ-025 With m_tready held high, the frame SHALL stream with no bubbles (one word per clk).
REQ-026 m_tlast SHALL be 1 only on the final sample word of each frame.
REQ-027 busy SHALL be 1 whenever either bank is committed or the FSM is not IDLE.

Reset
REQ-028 On rst_n=0 at a rising edge the block SHALL clear both banks' status to free, write index to 0, FSM to IDLE, frame sequence to 0, overflow_count to 0.
REQ-029 During and after reset until new data: m_tvalid=0, m_tlast=0, m_tdata=0, busy=0; bank RAM contents need not be cleared.
REQ-030 Reset mid-frame SHALL abort streaming immediately; no m_tlast is issued for the aborted frame.

Configuration
REQ-031 Macro MIC_FRAME_SEQ_NUM_EN defined: the block SHALL prepend one header word per frame, {16'hA55A, 16-bit frame sequence number}, sequence incrementing by 1 per frame (wrapping 16'hFFFF->0); frame length is SAMPLES_PER_FRAME+1 words.
REQ-032 Macro undefined: HDR state and sequence counter SHALL be absent; frame length is SAMPLES_PER_FRAME words.

Verification
REQ-033 SAMPLES_PER_FRAME=16, enable=1, 16 samples 0..15 every 4 clk, m_tready=1 -> 16 words 0..15 contiguous, m_tlast on 15, m_tvalid within 3 clk of sample 15.
REQ-034 m_tready toggled 1/0 every clk during a frame -> no word lost or duplicated, tdata/tlast stable while stalled.
REQ-035 m_tready=0, 40 samples of 1/clk -> banks fill after 32, overflow_count=8, busy=1; release m_tready -> frames 0..15 then 16..31.
REQ-036 enable dropped after 5 samples, then re-raised and 16 samples sent -> only the 16 new samples appear as one frame.
REQ-037 rst_n=0 for 1 clk at word 7 of a streaming frame -> m_tvalid=0, busy=0, overflow_count=0 next cycle; next full frame streams normally.
REQ-038 With MIC_FRAME_SEQ_NUM_EN, three frames -> header words 32'hA55A0000, 32'hA55A0001, 32'hA55A0002, each frame 17 words.
